// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
// Size codes follow the RISC-V load/store funct3 field.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE,
        WAIT
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// Word-aligned data memory bus with byte enables.
// master = load/store unit, slave = memory.
interface riscv_lsu_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension,
// and the size/alignment legality check. Purely combinational.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd_ext,
    output logic        bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be_st;

    assign byte_sel = rd[{off, 3'b000} +: 8];
    assign half_sel = rd[{off[1], 4'b0000} +: 16];

    // Decode size into lane pattern, data shaping and legality
    always_comb begin
        be_st  = 4'b1111;
        wd_rep = wd;
        rd_ext = rd;
        bad    = 1'b0;
        case (size)
            LDST_B: begin
                be_st  = 4'b0001 << off;
                wd_rep = {4{wd[7:0]}};
                rd_ext = {{24{byte_sel[7]}}, byte_sel};
            end
            LDST_BU: begin
                be_st  = 4'b0001 << off;
                wd_rep = {4{wd[7:0]}};
                rd_ext = {24'd0, byte_sel};
            end
            LDST_H: begin
                be_st  = 4'b0011 << {off[1], 1'b0};
                wd_rep = {2{wd[15:0]}};
                rd_ext = {{16{half_sel[15]}}, half_sel};
                bad    = off[0];
            end
            LDST_HU: begin
                be_st  = 4'b0011 << {off[1], 1'b0};
                wd_rep = {2{wd[15:0]}};
                rd_ext = {16'd0, half_sel};
                bad    = off[0];
            end
            LDST_W: begin
                bad    = (off != 2'b00);
            end
            default: begin
                bad    = 1'b1;
            end
        endcase
    end

    assign be = we ? be_st : 4'b1111;

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: request/ready sequencing, core stall and timeout abort.
// Lane steering lives in lsu_lane_align.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [31:0]       core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              core_bus_err_o,
    riscv_lsu_if.master       bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    lsu_state_t    state_q;
    lsu_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic [3:0]    be;
    logic [31:0]   wd_rep;
    logic [31:0]   rd_ext;
    logic          bad;
    logic          req_ok;
    logic          is_wait;
    logic          ready;
    logic          abort;
    logic          done;

    lsu_lane_align u_align (
        .we     (core_we_i),
        .size   (core_size_i),
        .off    (core_addr_i[1:0]),
        .wd     (core_wd_i),
        .rd     (bus.mem_rd_i),
        .be     (be),
        .wd_rep (wd_rep),
        .rd_ext (rd_ext),
        .bad    (bad)
    );

    assign ready   = bus.mem_ready_i;
    assign req_ok  = core_req_i & ~bad;
    assign is_wait = (state_q == WAIT);
    // Ready in the final cycle still wins over the timeout
    assign abort   = is_wait & req_ok & ~ready & (cnt_q == CNT_MAX);
    assign done    = req_ok & ready;

    // State and wait counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_ok & ~ready) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                if (~req_ok | ready | abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.mem_req_o  = req_ok & ~abort & ~rst_i;
    assign bus.mem_we_o   = core_we_i;
    assign bus.mem_be_o   = be;
    assign bus.mem_addr_o = {core_addr_i[31:2], 2'b00};
    assign bus.mem_wd_o   = wd_rep;

    assign core_stall_o    = req_ok & ~ready & ~abort & ~rst_i;
    assign core_misalign_o = core_req_i & bad & ~is_wait & ~rst_i;
    assign core_bus_err_o  = abort & ~rst_i;
    assign core_rd_o       = (done & ~core_we_i & ~rst_i) ? rd_ext : 32'd0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: vector table, hand sequences,
// and randomized transactions against a behavioural model.
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int errs   = 0;
    int checks = 0;

    riscv_lsu_if bus ();

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .core_req_i      (core_req),
        .core_we_i       (core_we),
        .core_size_i     (core_size),
        .core_addr_i     (core_addr),
        .core_wd_i       (core_wd),
        .core_rd_o       (core_rd),
        .core_stall_o    (stall),
        .core_misalign_o (misalign),
        .core_bus_err_o  (bus_err),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        logic        bad;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } mdl_t;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic mdl_t model(input logic we, input logic [2:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd);
        mdl_t r;
        int n;
        int off;
        bit sgn;
        bit ill;
        logic [31:0] m;
        logic [31:0] v;
        n = 4; sgn = 0; ill = 0;
        case (sz)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: n = 4;
            3'd4: n = 1;
            3'd5: n = 2;
            default: ill = 1;
        endcase
        off = int'(a[1:0]);
        r.bad = ill || ((off % n) != 0);
        r.wd = 32'd0;
        r.rd = 32'd0;
        if (we) begin
            r.be = 4'(((1 << n) - 1) << off);
            for (int i = 0; i < 4; i++)
                r.wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end else begin
            r.be = 4'hF;
            m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            v = (rd >> (8 * off)) & m;
            if (sgn && v[8*n-1]) v = v | ~m;
            r.rd = v;
        end
        return r;
    endfunction

    // One core access; w = cycle index at which ready is given (0 = same cycle)
    task automatic run_txn(input logic we, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int w,
                           input logic xbad, input logic [3:0] xbe,
                           input logic [31:0] xwd, input logic [31:0] xrd);
        for (int k = 0; k <= TO; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                core_req = 1'b1; core_we = we; core_size = sz;
                core_addr = a; core_wd = wd; bus.mem_rd_i = rd;
            end
            bus.mem_ready_i = (k == w);
            @(negedge clk);
            if (xbad) begin
                chk("bad_misalign", 32'(misalign), 32'd1);
                chk("bad_req", 32'(bus.mem_req_o), 32'd0);
                chk("bad_stall", 32'(stall), 32'd0);
                chk("bad_err", 32'(bus_err), 32'd0);
                break;
            end
            if (k == w) begin
                chk("done_req", 32'(bus.mem_req_o), 32'd1);
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_err", 32'(bus_err), 32'd0);
                chk("done_rd", core_rd, xrd);
                chk("done_be", 32'(bus.mem_be_o), 32'(xbe));
                chk("done_addr", bus.mem_addr_o, {a[31:2], 2'b00});
                chk("done_we", 32'(bus.mem_we_o), 32'(we));
                if (we) chk("done_wd", bus.mem_wd_o, xwd);
                break;
            end else if (k == TO) begin
                chk("abort_req", 32'(bus.mem_req_o), 32'd0);
                chk("abort_stall", 32'(stall), 32'd0);
                chk("abort_err", 32'(bus_err), 32'd1);
                chk("abort_rd", core_rd, 32'd0);
                break;
            end else begin
                chk("wait_req", 32'(bus.mem_req_o), 32'd1);
                chk("wait_stall", 32'(stall), 32'd1);
                chk("wait_err", 32'(bus_err), 32'd0);
                chk("wait_misalign", 32'(misalign), 32'd0);
                chk("wait_be", 32'(bus.mem_be_o), 32'(xbe));
                chk("wait_addr", bus.mem_addr_o, {a[31:2], 2'b00});
                chk("wait_rd", core_rd, 32'd0);
            end
        end
        @(posedge clk); #1;
        core_req = 1'b0;
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        chk("idle_req", 32'(bus.mem_req_o), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_flags", {30'd0, misalign, bus_err}, 32'd0);
        chk("idle_rd", core_rd, 32'd0);
    endtask

    vec_t tbl[12];
    mdl_t mr;

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 4'hF, 32'h0, 32'hFFFF_FF80};
        tbl[1]  = '{1'b0, 3'd4, 32'h101, 32'h0, 32'h80FF_1234, 1'b0, 4'hF, 32'h0, 32'h0000_0012};
        tbl[2]  = '{1'b0, 3'd1, 32'h202, 32'h0, 32'h80FF_1234, 1'b0, 4'hF, 32'h0, 32'hFFFF_80FF};
        tbl[3]  = '{1'b0, 3'd5, 32'h200, 32'h0, 32'h80FF_1234, 1'b0, 4'hF, 32'h0, 32'h0000_1234};
        tbl[4]  = '{1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFE_BABE, 1'b0, 4'hF, 32'h0, 32'hCAFE_BABE};
        tbl[5]  = '{1'b1, 3'd0, 32'h001, 32'h0000_00A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        tbl[6]  = '{1'b1, 3'd1, 32'h022, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[7]  = '{1'b1, 3'd2, 32'h004, 32'h1234_5678, 32'h0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0};
        tbl[8]  = '{1'b0, 3'd2, 32'h041, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 3'd3, 32'h040, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 3'd1, 32'h001, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 3'd7, 32'h000, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0};

        rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_size = 3'd2;
        core_addr = 32'h10; core_wd = 32'h0;
        bus.mem_rd_i = 32'h0; bus.mem_ready_i = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; core_req = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);

        // Zero-wait and rejected accesses from the vector table
        for (int i = 0; i < 12; i++)
            run_txn(tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].rd, 0,
                    tbl[i].bad, tbl[i].be, tbl[i].ewd, tbl[i].erd);

        // SH with three wait cycles
        run_txn(1'b1, 3'd1, 32'h22, 32'hDEAD_BEEF, 32'h0, 3,
                1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        // LHU timeout
        run_txn(1'b0, 3'd5, 32'h06, 32'h0, 32'h0, 99,
                1'b0, 4'hF, 32'h0, 32'h0);
        // LW: ready arrives in the same cycle the timeout would fire
        run_txn(1'b0, 3'd2, 32'h44, 32'h0, 32'h1357_2468, TO,
                1'b0, 4'hF, 32'h0, 32'h1357_2468);

        // Reset on the second WAIT cycle
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h80;
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        chk("rw_stall0", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_stall1", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rw_rst_stall", 32'(stall), 32'd0);
        chk("rw_rst_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; core_req = 1'b0;
        @(negedge clk);
        chk("rw_after_err", 32'(bus_err), 32'd0);
        chk("rw_after_req", 32'(bus.mem_req_o), 32'd0);
        // Full timeout length proves the counter restarted at 1
        run_txn(1'b0, 3'd2, 32'h84, 32'h0, 32'h0, 99,
                1'b0, 4'hF, 32'h0, 32'h0);

        // Randomized transactions against the model
        for (int t = 0; t < 200; t++) begin
            logic        we;
            logic [2:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            int          w;
            we = 1'($urandom);
            sz = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            rd = $urandom;
            w  = $urandom_range(0, 6);
            mr = model(we, sz, a, wd, rd);
            run_txn(we, sz, a, wd, rd, w, mr.bad, mr.be, mr.wd, mr.rd);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit between the RISC-V core's data port and data memory.
- Takes the core's per-instruction memory request (address, size, write data) and drives a word-aligned memory bus with byte enables.
- Sequences a request/ready handshake, stalls the core until completion or timeout, and sign/zero-extends load data.
- Flags misaligned or illegal-size accesses without touching memory.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles a request waits for mem_ready_i before abort (>=1)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  1  core requests a memory access this instruction
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  funct3 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data (low bits significant)
- core_rd_o  out  32  extended load data, valid in the completion cycle
- core_stall_o  out  1  holds the core PC and register-file write
- core_misalign_o  out  1  one-cycle pulse: misaligned or illegal size, access dropped
- core_bus_err_o  out  1  one-cycle pulse: timeout abort
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  {core_addr_i[31:2],2'b00}
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word, valid while mem_ready_i=1
- mem_ready_i  in  1  memory completes the current request

Behaviour:
- Reset (rst_i=1 sampled at edge): state<=IDLE, counter<=0.
- While rst_i is high, mem_req_o, core_stall_o, core_misalign_o and core_bus_err_o are forced to 0.
- Reset mid-WAIT aborts silently: no error pulse; memory must discard the request.
- Validity check (combinational):
  - illegal = size in {3,6,7}
  - misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0)
  - bad = illegal | misaligned
- FSM states: IDLE, WAIT.
- IDLE, core_req_i=0: all outputs idle, core_rd_o=0.
- IDLE, core_req_i & bad: no mem_req_o; core_misalign_o=1 this cycle; stall 0; stay in IDLE.
- IDLE, core_req_i & ~bad:
  - mem_req_o=1 combinationally.
  - mem_ready_i=1: zero-wait completion; stall 0; stay in IDLE.
  - Otherwise: stall 1; go to WAIT; counter<=1.
- WAIT:
  - mem_req_o=1 with address, we, be and wd held. These are stable because the core is stalled.
  - mem_ready_i=1: completion; stall 0; go to IDLE.
  - Else if counter==TIMEOUT_CYCLES: abort. mem_req_o=0 this cycle, stall 0, core_bus_err_o=1, go to IDLE.
  - Else: counter<=counter+1; stall 1.
- core_stall_o = core_req_i & ~bad & ~mem_ready_i & ~abort.
  - This makes the stall fall exactly in the completion cycle.
  - The core advances at that edge; the next instruction starts a fresh IDLE request.
- Store byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
  - Loads: mem_be_o=4'b1111
- Store write data: B {4{wd[7:0]}}; H {2{wd[15:0]}}; W wd.
- Load extraction, from mem_rd_i, selected by addr[1:0] and size:
  - B/H: sign-extend the selected byte/half.
  - BU/HU: zero-extend the selected byte/half.
  - W: full word.
- core_rd_o is combinational and meaningful only in the completion cycle; it is 0 otherwise.
- Counter width: $clog2(TIMEOUT_CYCLES+1). It never wraps, because abort occurs at equality.
- Simultaneous mem_ready_i and timeout: ready wins, giving normal completion and no error.
- Store completion: core_rd_o=0.
- Store abort: memory must not commit after seeing mem_req_o drop.

Decomposition:
- riscv_pkg holds:
  - size localparams LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5
  - lsu_state_t enum {IDLE, WAIT}
- One sub-module, lsu_lane_align: pure combinational. It generates byte enables and write-data replication, and does load extraction/extension plus the misaligned/illegal check. The FSM and counter stay in riscv_lsu.

Test Plan:
- Zero-wait LB, addr 0x103, mem_rd_i 0x80FF_1234, ready same cycle -> mem_addr_o 0x100, stall 0, core_rd_o 0xFFFF_FF80.
- SH, addr 0x22, wd 0xDEAD_BEEF, ready after 3 cycles -> mem_be_o 4'b1100, mem_wd_o 0xBEEF_BEEF, stall high 3 cycles, low in the ready cycle, then IDLE.
- LW, addr 0x41 -> mem_req_o never high, core_misalign_o one pulse, stall 0. Also size 3'd3 at 0x40 -> same response.
- LHU, addr 0x06, ready never, TIMEOUT_CYCLES=4 -> stall high 4 cycles, then mem_req_o 0 and core_bus_err_o pulse in the cycle counter==4, FSM IDLE.
- LW in WAIT with counter==TIMEOUT_CYCLES and ready=1 same cycle -> normal completion, core_rd_o=mem_rd_i, no bus_err.
- rst_i asserted on the 2nd WAIT cycle -> mem_req_o and stall 0 during reset, no error pulse, next request handled from IDLE with counter restarting at 1.
